// File: rtl/boot_loader.sv
// Serial program loader: parses a length-prefixed, checksummed byte stream and
// writes the assembled 32-bit words into program memory while holding the CPU.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned WORD_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] len_q,   len_d;
  logic [31:0] idx_q,   idx_d;
  logic [31:0] word_q,  word_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] data_q,  data_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [7:0]  sum_q,   sum_d;
  logic        take;
  logic [31:0] len_next;
  logic [31:0] word_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    word_d    = word_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    len_next  = {rx_byte, len_q[31:8]};
    word_next = {rx_byte, word_q[31:8]};

    // Gating with reset makes reset win over a byte offered on the same edge.
    rx_ready  = !reset && (state_q == S_LEN || state_q == S_DATA || state_q == S_CHECK);
    take      = rx_valid && rx_ready;
    mem_write = (state_q == S_WRITE);
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERROR);
    cpu_hold  = (state_q != S_DONE);

    unique case (state_q)
      S_LEN: begin
        if (take) begin
          len_d = len_next;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (len_next > 32'(WORD_LIMIT)) begin
              state_d = S_ERROR;
            end else if (len_next == 32'd0) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (take) begin
          word_d = word_next;
          sum_d  = sum_q + rx_byte;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Address and data are latched here so they stay put after the write.
            addr_d  = BASE_ADDR + (idx_q << 2);
            data_d  = word_next;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        idx_d   = idx_q + 32'd1;
        state_d = (idx_d == len_q) ? S_CHECK : S_DATA;
      end

      S_CHECK: begin
        if (take) begin
          state_d = (rx_byte == sum_q) ? S_DONE : S_ERROR;
        end
      end

      default: begin
        state_d = state_q;
      end
    endcase
  end

  assign mem_address = addr_q;
  assign mem_data    = data_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LEN;
      len_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

endmodule
